fetch_cycle: RTL and testbench

FETCH_CYCLE -- requirements
Module: fetch_cycle

---
 rtl/fetch_cycle_pkg.sv | 35 +++
 rtl/fetch_cycle_ifid_reg.sv | 26 ++
 rtl/fetch_cycle.sv | 137 +++++++++++++
 tb/tb_fetch_cycle.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_cycle_pkg.sv
// Fetch stage shared definitions.
// Widths, bubble encoding, IF/ID bundle and fetch FSM states.
package fetch_cycle_pkg;

    localparam int INSTR_W = 33;
    localparam int PC_W    = 9;

    localparam logic [INSTR_W-1:0] NOP_INSTR = '0;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        HOLD,
        DROP
    } fetchState_t;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc;
        logic [PC_W-1:0]    pcPlus4;
    } if_id_t;

    localparam if_id_t IFID_BUBBLE = '{
        instr:   NOP_INSTR,
        pc:      '0,
        pcPlus4: '0
    };

    function automatic logic [PC_W-1:0] pcPlus4(
        input logic [PC_W-1:0] pc
    );
        return pc + PC_W'(4);
    endfunction

endpackage

// File: rtl/fetch_cycle_ifid_reg.sv
// IF/ID pipeline register.
// Flush beats stall; an unloaded, unstalled cycle becomes a bubble.
module ifid_reg
    import fetch_cycle_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   stall,
    input  logic   flush,
    input  logic   load,
    input  if_id_t din,
    output if_id_t dout
);

    // flush > stall > load > bubble
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dout <= IFID_BUBBLE;
        end else if (flush) begin
            dout <= IFID_BUBBLE;
        end else if (!stall) begin
            dout <= load ? din : IFID_BUBBLE;
        end
    end

endmodule

// File: rtl/fetch_cycle.sv
// Fetch stage: PC, instruction memory handshake FSM and IF/ID.
// One request in flight; redirects drop stale responses.
module fetch_cycle
    import fetch_cycle_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               StallD,
    input  logic               FlushD,
    input  logic               PCSrcE,
    input  logic [PC_W-1:0]    PCTargetE,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               imem_valid,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    output logic [INSTR_W-1:0] InstrD,
    output logic [PC_W-1:0]    PCD,
    output logic [PC_W-1:0]    PCPlus4D
);

    fetchState_t        state;
    fetchState_t        stateNext;
    logic [PC_W-1:0]    PCF;
    logic [PC_W-1:0]    pcNext;
    logic [PC_W-1:0]    PCPlus4F;
    logic [PC_W-1:0]    dropPc;
    logic               reqNext;
    logic [PC_W-1:0]    addrNext;
    logic [INSTR_W-1:0] holdBuf;
    logic [INSTR_W-1:0] bufNext;
    logic               load;
    logic [INSTR_W-1:0] loadInstr;
    if_id_t             ifidIn;
    if_id_t             ifidOut;

    assign PCPlus4F = pcPlus4(PCF);
    assign dropPc   = PCSrcE ? PCTargetE : PCF;

    // State, PC, request and hold buffer registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            PCF       <= '0;
            imem_req  <= 1'b0;
            imem_addr <= '0;
            holdBuf   <= '0;
        end else begin
            state     <= stateNext;
            PCF       <= pcNext;
            imem_req  <= reqNext;
            imem_addr <= addrNext;
            holdBuf   <= bufNext;
        end
    end

    // Next state, next PC, next request and IF/ID load
    always_comb begin
        stateNext = state;
        pcNext    = PCF;
        reqNext   = imem_req;
        addrNext  = imem_addr;
        bufNext   = holdBuf;
        load      = 1'b0;
        loadInstr = imem_rdata;
        unique case (state)
            IDLE: begin
                stateNext = FETCH;
                reqNext   = 1'b1;
                addrNext  = PCF;
            end
            FETCH: begin
                if (PCSrcE) begin
                    pcNext = PCTargetE;
                    if (imem_valid) begin
                        addrNext = PCTargetE;
                    end else begin
                        stateNext = DROP;
                    end
                end else if (imem_valid) begin
                    if (StallD) begin
                        bufNext   = imem_rdata;
                        reqNext   = 1'b0;
                        stateNext = HOLD;
                    end else begin
                        load     = 1'b1;
                        pcNext   = PCPlus4F;
                        addrNext = PCPlus4F;
                    end
                end
            end
            HOLD: begin
                if (PCSrcE) begin
                    pcNext    = PCTargetE;
                    bufNext   = '0;
                    reqNext   = 1'b1;
                    addrNext  = PCTargetE;
                    stateNext = FETCH;
                end else if (!StallD) begin
                    load      = 1'b1;
                    loadInstr = holdBuf;
                    pcNext    = PCPlus4F;
                    reqNext   = 1'b1;
                    addrNext  = PCPlus4F;
                    stateNext = FETCH;
                end
            end
            DROP: begin
                pcNext = dropPc;
                if (imem_valid) begin
                    addrNext  = dropPc;
                    stateNext = FETCH;
                end
            end
        endcase
    end

    assign ifidIn = '{
        instr:   loadInstr,
        pc:      PCF,
        pcPlus4: PCPlus4F
    };

    ifid_reg u_ifid (
        .clk   (clk),
        .rst   (rst),
        .stall (StallD),
        .flush (FlushD | PCSrcE),
        .load  (load),
        .din   (ifidIn),
        .dout  (ifidOut)
    );

    assign InstrD   = ifidOut.instr;
    assign PCD      = ifidOut.pc;
    assign PCPlus4D = ifidOut.pcPlus4;

endmodule

// File: tb/tb_fetch_cycle.sv
// Testbench for fetch_cycle: directed vector table, reset
// sequence, then random traffic against an in-order fetch model.
module tb_fetch_cycle;
    import fetch_cycle_pkg::*;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               StallD = 1'b0;
    logic               FlushD = 1'b0;
    logic               PCSrcE = 1'b0;
    logic [PC_W-1:0]    PCTargetE = '0;
    logic [INSTR_W-1:0] imem_rdata = '0;
    logic               imem_valid = 1'b0;
    logic               imem_req;
    logic [PC_W-1:0]    imem_addr;
    logic [INSTR_W-1:0] InstrD;
    logic [PC_W-1:0]    PCD;
    logic [PC_W-1:0]    PCPlus4D;

    int nChecks = 0;
    int nFails  = 0;

    fetch_cycle dut (
        .clk        (clk),
        .rst        (rst),
        .StallD     (StallD),
        .FlushD     (FlushD),
        .PCSrcE     (PCSrcE),
        .PCTargetE  (PCTargetE),
        .imem_rdata (imem_rdata),
        .imem_valid (imem_valid),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .InstrD     (InstrD),
        .PCD        (PCD),
        .PCPlus4D   (PCPlus4D)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic            stall;
        logic            flush;
        logic            pcsrc;
        logic [PC_W-1:0] tgt;
        logic            valid;
        logic            eReq;
        logic [PC_W-1:0] eAddr;
        logic            eBub;
        logic [PC_W-1:0] ePcd;
    } vec_t;

    vec_t vecs[31];

    function automatic vec_t mk(
        input int s, input int f, input int p, input int t,
        input int v, input int r, input int a, input int b,
        input int pc
    );
        vec_t m;
        m.stall = 1'(s);
        m.flush = 1'(f);
        m.pcsrc = 1'(p);
        m.tgt   = 9'(t);
        m.valid = 1'(v);
        m.eReq  = 1'(r);
        m.eAddr = 9'(a);
        m.eBub  = 1'(b);
        m.ePcd  = 9'(pc);
        return m;
    endfunction

    function automatic logic [INSTR_W-1:0] instrOf(
        input logic [PC_W-1:0] a
    );
        return {1'b1, 8'hA5, 15'h0, a};
    endfunction

    function automatic logic [50:0] ifidExp(
        input logic bub, input logic [PC_W-1:0] pc
    );
        logic [PC_W-1:0] p4;
        p4 = pc + 9'd4;
        if (bub) return '0;
        return {instrOf(pc), pc, p4};
    endfunction

    task automatic check(
        input string name, input logic [63:0] act,
        input logic [63:0] exp
    );
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [50:0] ifidNow();
        return {InstrD, PCD, PCPlus4D};
    endfunction

    logic               s;
    logic               f;
    logic               p;
    logic               v;
    logic               reqB;
    logic [PC_W-1:0]    addrB;
    logic [PC_W-1:0]    t;
    logic [PC_W-1:0]    expPc;
    logic [50:0]        prevIfid;
    int                 waitCnt;
    int                 curLat;
    int                 deliveries;

    initial begin
        vecs[0]  = mk(0,0,0,0,0,       1,0,1,0);
        vecs[1]  = mk(0,0,0,0,1,       1,4,0,0);
        vecs[2]  = mk(0,0,0,0,1,       1,8,0,4);
        vecs[3]  = mk(0,0,0,0,1,       1,'h0C,0,8);
        vecs[4]  = mk(0,0,0,0,0,       1,'h0C,1,0);
        vecs[5]  = mk(0,0,0,0,0,       1,'h0C,1,0);
        vecs[6]  = mk(0,0,0,0,1,       1,'h10,0,'h0C);
        vecs[7]  = mk(1,0,0,0,1,       0,'h10,0,'h0C);
        vecs[8]  = mk(1,0,0,0,0,       0,'h10,0,'h0C);
        vecs[9]  = mk(0,0,0,0,0,       1,'h14,0,'h10);
        vecs[10] = mk(0,0,0,0,0,       1,'h14,1,0);
        vecs[11] = mk(0,0,0,0,1,       1,'h18,0,'h14);
        vecs[12] = mk(0,0,0,0,1,       1,'h1C,0,'h18);
        vecs[13] = mk(0,0,0,0,1,       1,'h20,0,'h1C);
        vecs[14] = mk(0,0,1,'h40,0,    1,'h20,1,0);
        vecs[15] = mk(0,0,0,0,1,       1,'h40,1,0);
        vecs[16] = mk(0,0,0,0,1,       1,'h44,0,'h40);
        vecs[17] = mk(0,0,1,'h1F8,1,   1,'h1F8,1,0);
        vecs[18] = mk(0,0,0,0,1,       1,'h1FC,0,'h1F8);
        vecs[19] = mk(0,0,0,0,1,       1,0,0,'h1FC);
        vecs[20] = mk(1,1,0,0,0,       1,0,1,0);
        vecs[21] = mk(0,0,0,0,1,       1,4,0,0);
        vecs[22] = mk(1,0,0,0,1,       0,4,0,0);
        vecs[23] = mk(1,0,1,'h80,0,    1,'h80,1,0);
        vecs[24] = mk(0,0,0,0,1,       1,'h84,0,'h80);
        vecs[25] = mk(1,0,0,0,0,       1,'h84,0,'h80);
        vecs[26] = mk(0,1,0,0,0,       1,'h84,1,0);
        vecs[27] = mk(0,0,1,'h100,0,   1,'h84,1,0);
        vecs[28] = mk(0,0,1,'h120,0,   1,'h84,1,0);
        vecs[29] = mk(0,0,0,0,1,       1,'h120,1,0);
        vecs[30] = mk(0,0,0,0,1,       1,'h124,0,'h120);

        // reset state
        @(negedge clk);
        @(negedge clk);
        check("reset_req", 64'(imem_req), 64'(0));
        check("reset_addr", 64'(imem_addr), 64'(0));
        check("reset_ifid", 64'(ifidNow()), 64'(0));
        rst = 1'b1;

        // directed vector table, memory driven from the table
        for (int i = 0; i < 31; i++) begin
            StallD     = vecs[i].stall;
            FlushD     = vecs[i].flush;
            PCSrcE     = vecs[i].pcsrc;
            PCTargetE  = vecs[i].tgt;
            imem_valid = vecs[i].valid;
            imem_rdata = vecs[i].valid ? instrOf(imem_addr)
                                       : 33'h0BAD0BAD;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_req", i),
                  64'(imem_req), 64'(vecs[i].eReq));
            check($sformatf("vec%0d_addr", i),
                  64'(imem_addr), 64'(vecs[i].eAddr));
            check($sformatf("vec%0d_ifid", i), 64'(ifidNow()),
                  64'(ifidExp(vecs[i].eBub, vecs[i].ePcd)));
            @(negedge clk);
        end
        StallD = 1'b0;
        FlushD = 1'b0;
        PCSrcE = 1'b0;
        imem_valid = 1'b0;

        // reset pulsed while the request for 0x124 is outstanding
        rst = 1'b0;
        #1;
        check("async_rst_outs",
              64'({imem_req, imem_addr, ifidNow()}), 64'(0));
        @(posedge clk);
        #1;
        check("rst_held_outs",
              64'({imem_req, imem_addr, ifidNow()}), 64'(0));
        @(negedge clk);
        imem_valid = 1'b1;
        imem_rdata = instrOf(9'h124);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_req",
              64'({imem_req, imem_addr}), 64'({1'b1, 9'h000}));
        check("late_valid_ignored", 64'(ifidNow()),
              64'(ifidExp(1'b1, 9'h0)));
        @(negedge clk);
        imem_rdata = instrOf(9'h000);
        @(posedge clk);
        #1;
        check("post_rst_first", 64'(ifidNow()),
              64'(ifidExp(1'b0, 9'h0)));
        @(negedge clk);
        imem_valid = 1'b0;

        // random traffic against an in-order delivery model
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        expPc = '0;
        waitCnt = 0;
        curLat = 1;
        deliveries = 0;
        for (int c = 0; c < 3000; c++) begin
            s = ($urandom % 4) == 0;
            p = (c > 0) && (($urandom % 20) == 0);
            f = p || (s && (($urandom % 3) == 0));
            t = 9'($urandom_range(0, 127) * 4);
            reqB  = imem_req;
            addrB = imem_addr;
            if (reqB && waitCnt == 0) curLat = $urandom_range(1, 4);
            v = reqB && (waitCnt >= curLat - 1);
            StallD     = s;
            FlushD     = f;
            PCSrcE     = p;
            PCTargetE  = t;
            imem_valid = v;
            imem_rdata = v ? instrOf(addrB) : 33'($urandom);
            prevIfid   = ifidNow();
            @(posedge clk);
            #1;
            if (v) waitCnt = 0;
            else if (reqB) waitCnt++;
            if (p || f) begin
                check("rnd_flush_bubble", 64'(ifidNow()), 64'(0));
            end else if (s) begin
                check("rnd_stall_hold", 64'(ifidNow()),
                      64'(prevIfid));
            end else if (InstrD !== NOP_INSTR) begin
                check("rnd_deliver", 64'(ifidNow()),
                      64'(ifidExp(1'b0, expPc)));
                expPc = expPc + 9'd4;
                deliveries++;
            end else begin
                check("rnd_bubble_fields",
                      64'({PCD, PCPlus4D}), 64'(0));
            end
            if (p) expPc = t;
            if (reqB && !v) begin
                check("rnd_req_stable",
                      64'({imem_req, imem_addr}),
                      64'({1'b1, addrB}));
            end
            @(negedge clk);
        end
        nChecks++;
        if (deliveries < 200) begin
            nFails++;
            $display("FAIL rnd_progress: got %0d deliveries, need >= 200",
                     deliveries);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 nChecks, nFails);
        $finish;
    end

endmodule
